// File: rtl/mul_issue_ctrl_pkg.sv
//==============================================================================
// Module      : mul_issue_ctrl_pkg
// Description : Shared constants and helpers for the multiplier issue path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mul_issue_ctrl_pkg;

   localparam int DATA_W  = 32;   // operand/result width of the Booth multiplier
   localparam int RD_W    = 5;    // destination register tag width
   localparam int MUL_LAT = 2;    // multiplier register stages

   // Population count of the three occupancy bits (stage 1, stage 2, output buffer).
   function automatic logic [1:0] count3(input logic a, input logic b, input logic c);
      return {1'b0, a} + {1'b0, b} + {1'b0, c};
   endfunction

endpackage : mul_issue_ctrl_pkg

`default_nettype wire

// File: rtl/mul_issue_ctrl_rr_arb2.sv
//==============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter with one-hot grant.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd_en,
   output logic [1:0] gnt
);

   // Port granted most recently; resetting to 1 makes port 0 the first preference.
   logic r_last;

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || r_last)) begin
         gnt = 2'b01;
      end else if (req[1]) begin
         gnt = 2'b10;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= 1'b1;
      end else if (upd_en && (|gnt)) begin
         r_last <= gnt[1];
      end
   end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
//==============================================================================
// Module      : mul_issue_ctrl
// Description : Two-port issue control and result buffering around an external
//               two-stage pipelined multiplier with global stall.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mul_issue_ctrl #(
   parameter int DATA_W = mul_issue_ctrl_pkg::DATA_W,
   parameter int RD_W   = mul_issue_ctrl_pkg::RD_W
) (
   input  logic              clk,
   input  logic              rst,
   // requester 0
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [RD_W-1:0]   req0_rd,
   // requester 1
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [RD_W-1:0]   req1_rd,
   // multiplier
   output logic [DATA_W-1:0] mul_a,
   output logic [DATA_W-1:0] mul_b,
   output logic              mul_stall,
   input  logic [DATA_W-1:0] mul_m,
   // result
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_src,
   output logic [RD_W-1:0]   res_rd,
   // hazard query
   input  logic [RD_W-1:0]   chk_rd,
   output logic              chk_hit,
   output logic [1:0]        inflight
);

   import mul_issue_ctrl_pkg::*;

   localparam int c_last = MUL_LAT - 1;

   logic [1:0]         w_req;
   logic [1:0]         w_gnt;
   logic               w_stall;
   logic               w_xfer;
   logic               w_ob_load;
   logic [RD_W-1:0]    w_issue_rd;
   logic [MUL_LAT-1:0] w_stg_hit;
   logic               w_ob_hit;

   // Per-stage shadow of the multiplier pipeline: index 0 is s1, c_last is s2.
   logic [MUL_LAT-1:0] r_stg_valid;
   logic [MUL_LAT-1:0] r_stg_src;
   logic [RD_W-1:0]    r_stg_rd [MUL_LAT];

   logic               r_ob_valid;
   logic               r_ob_src;
   logic [RD_W-1:0]    r_ob_rd;
   logic [DATA_W-1:0]  r_ob_data;

   assign w_req     = {req1_valid, req0_valid};
   assign w_stall   = r_stg_valid[c_last] & r_ob_valid & ~res_ready;
   assign w_xfer    = (|w_gnt) & ~w_stall;
   assign w_ob_load = r_stg_valid[c_last] & (~r_ob_valid | res_ready);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (w_req),
      .upd_en (w_xfer),
      .gnt    (w_gnt)
   );

   assign req0_ready = w_gnt[0] & ~w_stall;
   assign req1_ready = w_gnt[1] & ~w_stall;
   assign mul_stall  = w_stall;

   always_comb begin
      mul_a      = '0;
      mul_b      = '0;
      w_issue_rd = req0_rd;
      if (w_gnt[0]) begin
         mul_a = req0_a;
         mul_b = req0_b;
      end else if (w_gnt[1]) begin
         mul_a      = req1_a;
         mul_b      = req1_b;
         w_issue_rd = req1_rd;
      end
   end

   // Stage tracking advances in lockstep with the multiplier registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stg_valid <= '0;
         r_stg_src   <= '0;
         for (int i = 0; i < MUL_LAT; i++) begin
            r_stg_rd[i] <= '0;
         end
      end else if (!w_stall) begin
         r_stg_valid[0] <= w_xfer;
         r_stg_src[0]   <= w_gnt[1];
         r_stg_rd[0]    <= w_issue_rd;
         for (int i = 1; i < MUL_LAT; i++) begin
            r_stg_valid[i] <= r_stg_valid[i-1];
            r_stg_src[i]   <= r_stg_src[i-1];
            r_stg_rd[i]    <= r_stg_rd[i-1];
         end
      end
   end

   // A drain and a refill in the same cycle keep res_valid high without a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ob_valid <= 1'b0;
         r_ob_src   <= 1'b0;
         r_ob_rd    <= '0;
         r_ob_data  <= '0;
      end else if (w_ob_load) begin
         r_ob_valid <= 1'b1;
         r_ob_src   <= r_stg_src[c_last];
         r_ob_rd    <= r_stg_rd[c_last];
         r_ob_data  <= mul_m;
      end else if (res_ready) begin
         r_ob_valid <= 1'b0;
      end
   end

   assign res_valid = r_ob_valid;
   assign res_data  = r_ob_data;
   assign res_src   = r_ob_src;
   assign res_rd    = r_ob_rd;

   generate
      for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_hit
         assign w_stg_hit[gi] = r_stg_valid[gi] && (r_stg_rd[gi] == chk_rd);
      end
   endgenerate

   // Tag 0 is the hardwired-zero register and never creates a hazard.
   assign w_ob_hit = r_ob_valid && (r_ob_rd == chk_rd);
   assign chk_hit  = (chk_rd != '0) && ((|w_stg_hit) || w_ob_hit);

   assign inflight = count3(r_stg_valid[0], r_stg_valid[c_last], r_ob_valid);

endmodule : mul_issue_ctrl

`default_nettype wire

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width (fixed by the 32-bit Booth multiplier).
REQ-002 SHALL have parameter RD_W, default 5, destination register tag width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports req0_valid in 1 / req0_ready out 1 / req0_a in DATA_W / req0_b in DATA_W / req0_rd in RD_W  requester 0 issue handshake, operands, tag.
REQ-007 SHALL have ports req1_valid / req1_ready / req1_a / req1_b / req1_rd, same directions and widths, for requester 1.
REQ-008 SHALL have port mul_a  out  DATA_W  multiplicand to multiplier.
REQ-009 SHALL have port mul_b  out  DATA_W  multiplier operand to multiplier.
REQ-010 SHALL have port mul_stall  out  1  freezes both multiplier pipeline registers.
REQ-011 SHALL have port mul_m  in  DATA_W  multiplier product, low 32 bits.
REQ-012 SHALL have ports res_valid out 1 / res_ready in 1 / res_data out DATA_W / res_src out 1 / res_rd out RD_W  result handshake, product, requester id, tag.
REQ-013 SHALL have ports chk_rd  in  RD_W  and chk_hit  out  1  hazard query.
REQ-014 SHALL have port inflight  out  2  count of valid entries (stage 1 + stage 2 + output buffer, 0..3).

Function
REQ-015 SHALL model multiplier timing as two register stages: operands applied in cycle T appear on mul_m in cycle T+2 when mul_stall is low at both edges.
REQ-016 SHALL track each stage with a valid bit, src bit and rd tag (s1, s2) that advance exactly when the multiplier registers advance.
REQ-017 SHALL hold a one-entry output buffer (ob) with data/src/rd/valid; res_valid = ob valid; res_* driven only from ob.
REQ-018 SHALL compute stall = s2_valid AND ob_valid AND NOT res_ready; mul_stall = stall; s1/s2 SHALL hold while stall is high.
REQ-019 SHALL load ob from mul_m/s2 when s2_valid and (NOT ob_valid OR res_ready); SHALL clear ob_valid when res_ready and no load occurs.
REQ-020 SHALL give 3-cycle issue-to-result latency: accept at edge ending cycle T, res_valid high in cycle T+3, absent stall.
REQ-021 SHALL arbitrate round-robin: with both valid, grant the port not granted last; with one valid, grant it; pointer updates only on an accepted grant.
REQ-022 SHALL assert reqN_ready = (port N granted) AND NOT stall; transfer occurs when valid and ready both high.
REQ-023 SHALL drive mul_a/mul_b from the granted port, zero when no grant; s1_valid loads 1 on transfer, 0 otherwise (bubble).
REQ-024 SHALL accept one new operation per cycle with back-to-back results when res_ready is continuously high.
REQ-025 SHALL drive chk_hit combinationally high when chk_rd != 0 and matches rd of any valid s1, s2 or ob entry; chk_rd = 0 never hits.
REQ-026 SHALL keep inflight = s1_valid + s2_valid + ob_valid.
REQ-027 SHALL, with res_ready low, accept at most 3 operations then deassert both readies until res_ready rises; no result lost or duplicated.
REQ-028 SHALL, on same-cycle ob drain and s2 load, present the new entry in ob the next cycle with no bubble.

Reset
REQ-029 SHALL clear s1/s2/ob valid bits, round-robin pointer (next preference = port 0), on rst at clock edge.
REQ-030 SHALL reset outputs: res_valid 0, req0_ready/req1_ready follow REQ-022 (high for valid port after reset), mul_stall 0, chk_hit 0, inflight 0; data/tag regs reset to 0.
REQ-031 SHALL discard all in-flight operations when rst asserts mid-operation; no result is emitted for them.

Structure
REQ-032 SHALL place DATA_W, RD_W and the multiplier latency constant (2) in the shared multiplier package.
REQ-033 SHALL implement the round-robin arbiter as sub-module rr_arb2 (2 requests, grant one-hot, update enable).
REQ-034 SHALL NOT instantiate the multiplier; top-level connects mul_* to BoothMul, rst inverted to its active-low reset.

Verification
REQ-035 Single issue: req0 a=7 b=6 rd=3, res_ready=1 -> res_valid in cycle T+3, res_data=42, res_src=0, res_rd=3, one cycle.
REQ-036 Contention: both valid every cycle (req0 a=2 b=3, req1 a=4 b=5) -> grants alternate 0,1,0,1; results 6,20,6,20 in order.
REQ-037 Backpressure: res_ready=0, 5 issues attempted -> 3 accepted, mul_stall high, inflight=3; res_ready=1 -> 3 results in order, then remaining 2 accepted.
REQ-038 Hazard: issue rd=9 -> chk_rd=9 gives chk_hit=1 from T+1 until result handshake; chk_rd=0 with rd=0 issued -> chk_hit=0.
REQ-039 Wrap/width: a=0xFFFFFFFF b=0xFFFFFFFF -> res_data=0x00000001; a=0x80000000 b=2 -> 0x00000000.
REQ-040 Reset mid-flight: 3 ops in flight, rst one cycle -> res_valid 0, inflight 0, next result only from post-reset issue.
